// File: rtl/be_pkg.sv
// Shared definitions for the memory responder: FSM states, RV32I load/store
// size codes and the small lane/extension helpers used around the RAM.
package be_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Misalignment or an illegal size code; the address range is checked by the caller.
    function automatic logic decode_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad_f3;
        logic misalign;
        if (we) begin
            bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end else begin
            bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        end
        misalign = ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'b00);
        return bad_f3 || misalign;
    endfunction

    // Byte lanes touched by a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data so every candidate lane carries it.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3)
            F3_B:    lanes = {4{wd[7:0]}};
            F3_H:    lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    // Align the read word to the requested byte and sign/zero extend.
    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    res = {{24{sh[7]}}, sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   res = {24'h0, sh[7:0]};
            F3_HU:   res = {16'h0, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Synchronous single-port RAM built from four independent byte lanes.
// Writes honour the byte enables; reads return the whole word one edge later.
module data_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH_WORDS-1];
            logic [7:0] rdata_q;

            // One lane: byte write when enabled, registered read otherwise.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) begin
                        if (be[gi]) begin
                            mem[addr] <= wdata[8*gi +: 8];
                        end
                    end else begin
                        rdata_q <= mem[addr];
                    end
                end
            end

            assign rdata[8*gi +: 8] = rdata_q;
        end
    endgenerate

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder in front of a byte-lane RAM.
// Requests are captured in IDLE, optionally delayed by wait states, perform one
// RAM access and are answered with a registered response held until consumed.
module mem_responder
    import be_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic          handshake;
    logic          cap_err;
    logic          ram_en;
    logic [31:0]   ram_rdata;

    assign handshake = req_valid && req_ready_q;
    assign cap_err   = decode_err(req_we, req_funct3, req_addr[1:0])
                    || ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

    // A reset landing on the ACCESS edge must suppress the RAM operation.
    assign ram_en = (state_q == ACCESS) && !rst;

    data_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_data_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .be    (store_be(funct3_q, addr_q[1:0])),
        .addr  (addr_q[AW+1:2]),
        .wdata (store_lanes(funct3_q, wdata_q)),
        .rdata (ram_rdata)
    );

    // State and output registers; RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            funct3_q     <= 3'd0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next state and wait-state counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    if (cap_err) begin
                        state_d = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                if (resp_valid_q && resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture and response formation; the response is loaded on the
    // first RESP cycle, when the RAM's registered read data is available.
    always_comb begin
        we_d         = we_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (state_q == IDLE && handshake) begin
            we_d     = req_we;
            addr_d   = req_addr[AW+1:0];
            funct3_d = req_funct3;
            wdata_d  = req_wdata;
            err_d    = cap_err;
        end
        if (state_q == RESP) begin
            if (!resp_valid_q) begin
                resp_valid_d = 1'b1;
                resp_err_d   = err_q;
                resp_rdata_d = (err_q || we_q) ? 32'd0 : load_format(ram_rdata, funct3_q, addr_q[1:0]);
            end else if (resp_ready) begin
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
            end
        end
        req_ready_d = (state_d == IDLE);
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus randomized loads/stores
// checked against a byte-addressed reference memory.
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 1;
    localparam int LAT_OK = WAITC + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mref [0:DEPTH*4-1];

    mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic ref_err(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        int sz;
        sz = ref_size(f3);
        if (sz == 0) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if ((addr % 32'(sz)) != 0) return 1'b1;
        if ((addr / 4) >= 32'(DEPTH)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
        int sz;
        logic [31:0] v;
        sz = ref_size(f3);
        v = 32'd0;
        for (int i = 0; i < sz; i++) v = v + (32'(mref[int'(addr) + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        sz = ref_size(f3);
        for (int i = 0; i < sz; i++) mref[int'(addr) + i] = 8'(wd >> (8 * i));
    endtask

    // ---------------- driver ----------------
    // One complete transaction; lat = edges from handshake to resp_valid, -1 on timeout.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (resp_valid !== 1'b1) lat = -1;
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        $display("xact we=%0d addr=%08h f3=%0d wdata=%08h -> rdata=%08h err=%0d lat=%0d",
                 we, addr, f3, wd, rd, er, lat);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %0b want 0", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got %0b want 0", resp_err); end
        n_cmp++; if (resp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_resp_rdata got %08h want 00000000", resp_rdata); end
    endtask

    task automatic test_init();
        logic [31:0] rd; logic er; int lat; logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            xact(1'b1, 32'(4 * i), 3'b010, w, rd, er, lat);
            ref_store(32'(4 * i), 3'b010, w);
        end
        w = $urandom;
        xact(1'b1, 32'(4 * (DEPTH - 1)), 3'b010, w, rd, er, lat);
        ref_store(32'(4 * (DEPTH - 1)), 3'b010, w);
        xact(1'b0, 32'(4 * (DEPTH - 1)), 3'b010, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== w || er !== 1'b0) begin n_bad++; $display("FAIL top_word got %08h/%0b want %08h/0", rd, er, w); end
    endtask

    task automatic test_directed();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
        ref_store(32'h10, 3'b010, 32'hDEADBEEF);
        n_cmp++; if (er !== 1'b0 || rd !== 32'd0 || lat !== LAT_OK) begin n_bad++; $display("FAIL sw_resp got rd=%08h err=%0b lat=%0d want 0/0/%0d", rd, er, lat, LAT_OK); end
        xact(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data got %08h want deadbeef", rd); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL lw_err got %0b want 0", er); end
        n_cmp++; if (lat !== LAT_OK) begin n_bad++; $display("FAIL lw_latency got %0d want %0d", lat, LAT_OK); end
        xact(1'b0, 32'h13, 3'b000, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFFFFDE) begin n_bad++; $display("FAIL lb got %08h want ffffffde", rd); end
        xact(1'b0, 32'h13, 3'b100, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'h000000DE) begin n_bad++; $display("FAIL lbu got %08h want 000000de", rd); end
        xact(1'b0, 32'h12, 3'b001, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFFDEAD) begin n_bad++; $display("FAIL lh got %08h want ffffdead", rd); end
        xact(1'b0, 32'h10, 3'b101, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0000BEEF) begin n_bad++; $display("FAIL lhu got %08h want 0000beef", rd); end
        xact(1'b1, 32'h11, 3'b000, 32'h00000055, rd, er, lat);
        ref_store(32'h11, 3'b000, 32'h55);
        xact(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEAD55EF) begin n_bad++; $display("FAIL sb_merge got %08h want dead55ef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        logic        ewe [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] ead [5] = '{32'h2, 32'h1, 32'(4 * DEPTH), 32'h0, 32'h0};
        logic [2:0]  ef3 [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            xact(ewe[i], ead[i], ef3[i], 32'hA5A5A5A5, rd, er, lat);
            n_cmp++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin n_bad++; $display("FAIL err_case%0d got err=%0b rd=%08h lat=%0d want 1/0/1", i, er, rd, lat); end
        end
        xact(1'b0, 32'h0, 3'b010, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== ref_load(32'h0, 3'b010)) begin n_bad++; $display("FAIL err_no_write got %08h want %08h", rd, ref_load(32'h0, 3'b010)); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; logic [31:0] exp;
        exp = ref_load(32'h10, 3'b010);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'd0;
        @(posedge clk); #1; req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_timeout got %0b want 1", resp_valid); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = (c % 2 == 0); req_we = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'h0;
            @(posedge clk); #1;
            req_valid = 1'b0;
            n_cmp++; if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0)
                begin n_bad++; $display("FAIL bp_hold%0d got v=%0b rd=%08h rdy=%0b want 1/%08h/0", c, resp_valid, resp_rdata, req_ready, exp); end
        end
        resp_ready = 1'b1; @(posedge clk); #1; resp_ready = 1'b0;
        xact(1'b0, 32'h10, 3'b010, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== exp) begin n_bad++; $display("FAIL bp_ignored got %08h want %08h", rd, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        xact(1'b0, 32'h4, 3'b010, 32'd0, rd, er, lat);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %0b want 1", req_ready); end
        xact(1'b0, 32'h8, 3'b010, 32'd0, rd, er, lat);
        n_cmp++; if (rd !== ref_load(32'h8, 3'b010) || lat !== LAT_OK) begin n_bad++; $display("FAIL b2b_second got %08h lat=%0d want %08h lat=%0d", rd, lat, ref_load(32'h8, 3'b010), LAT_OK); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; logic [31:0] prior;
        prior = ref_load(32'h20, 3'b010);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010;
            req_wdata = (k == 0) ? 32'h12345678 : 32'hCAFEF00D;
            @(posedge clk); #1; req_valid = 1'b0;
            if (k == 1) begin @(posedge clk); #1; end
            rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
            n_cmp++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid%0d got v=%0b rdy=%0b want 0/1", k, resp_valid, req_ready); end
            xact(1'b0, 32'h20, 3'b010, 32'd0, rd, er, lat);
            n_cmp++; if (rd !== prior) begin n_bad++; $display("FAIL rst_mid%0d_nowrite got %08h want %08h", k, rd, prior); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat;
        logic we; logic [31:0] addr; logic [2:0] f3; logic [31:0] wd;
        logic eexp; logic [31:0] dexp;
        for (int n = 0; n < 120; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 9) == 0) addr = 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
            else addr = 32'($urandom_range(0, 63));
            eexp = ref_err(we, addr, f3);
            dexp = (eexp || we) ? 32'd0 : ref_load(addr, f3);
            xact(we, addr, f3, wd, rd, er, lat);
            if (!eexp && we) ref_store(addr, f3, wd);
            n_cmp++; if (er !== eexp || rd !== dexp || lat !== (eexp ? 1 : LAT_OK))
                begin n_bad++; $display("FAIL rand%0d got err=%0b rd=%08h lat=%0d want %0b/%08h/%0d", n, er, rd, lat, eexp, dexp, eexp ? 1 : LAT_OK); end
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_funct3 = 3'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        for (int i = 0; i < DEPTH * 4; i++) mref[i] = 8'h00;
        test_reset();
        test_init();
        test_directed();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, extra wait states inserted before each access (0..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_funct3  input  3  RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  initiator consumes the response.
REQ-013 SHALL have port resp_rdata  output  32  load data, aligned and extended; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  misaligned, out-of-range or illegal funct3.

Function
REQ-015 SHALL implement FSM IDLE -> WAIT -> ACCESS -> RESP -> IDLE; IDLE goes directly to ACCESS when WAIT_CYCLES = 0.
REQ-016 SHALL assert req_ready only in IDLE; a handshake happens when req_valid && req_ready, capturing we/addr/funct3/wdata into registers.
REQ-017 SHALL ignore request inputs outside IDLE; no queuing, one outstanding request.
REQ-018 SHALL decode error at capture: halfword with addr[0] = 1, word with addr[1:0] != 0, word index >= DEPTH_WORDS, store funct3 not in {000, 001, 010}, or load funct3 not in {000, 001, 010, 100, 101}.
REQ-019 SHALL route an errored request IDLE -> RESP directly with resp_err = 1, resp_rdata = 0, and no memory write.
REQ-020 SHALL count WAIT_CYCLES cycles in WAIT with a 4-bit down-counter loaded at the handshake, then enter ACCESS.
REQ-021 SHALL in ACCESS perform exactly one RAM operation: a store writes bytes selected by byte-enable (SB 1 lane, SH 2 lanes, SW 4 lanes) with wdata replicated to lane position; a load reads the full word.
REQ-022 SHALL in RESP hold resp_valid = 1 with stable resp_rdata/resp_err until resp_ready = 1, then return to IDLE on the next edge.
REQ-023 SHALL form load data by shifting the read word right by 8*addr[1:0], then sign-extending (B, H) or zero-extending (BU, HU).
REQ-024 SHALL give a total latency of WAIT_CYCLES + 2 cycles from handshake edge to resp_valid for non-error requests, and 1 cycle for errors.
REQ-025 SHALL allow a new handshake in the cycle after a RESP consumption (no same-cycle resp/req overlap).

Reset
REQ-026 SHALL on rst force state IDLE, wait counter 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, req_ready = 1 next cycle.
REQ-027 SHALL on rst mid-operation abandon the request; a store in WAIT is never written, and a store whose ACCESS edge coincides with rst is also not written.
REQ-028 SHALL leave RAM contents unchanged by reset.

Structure
REQ-029 SHALL take the FSM state enum (IDLE, WAIT, ACCESS, RESP) and funct3 size constants from the shared be_pkg package.
REQ-030 SHALL instantiate one sub-module, data_ram: a synchronous single-port, 4-lane byte-enabled RAM of DEPTH_WORDS words.
REQ-031 SHALL register all outputs; no combinational path from req_* to resp_*.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata = 0xDEADBEEF, resp_err = 0, resp_valid 3 cycles after handshake (WAIT_CYCLES = 1).
REQ-033 After REQ-032: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-034 SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 -> 0xDEAD55EF.
REQ-035 LW @0x02, SH @0x01, LW @(4*DEPTH_WORDS), funct3 = 011 -> each resp_err = 1, resp_rdata = 0, resp_valid 1 cycle after handshake, memory unchanged.
REQ-036 Hold resp_ready = 0 for 5 cycles -> resp_valid and data stable, req_ready = 0 throughout, req_valid pulses ignored.
REQ-037 Assert rst while in WAIT of SW 0x12345678 @0x20 -> next cycle IDLE, resp_valid = 0; subsequent LW @0x20 returns the prior value.
